// File: rtl/functions_pkg.sv
// Shared elaboration-time helper functions.
package functions_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/settings_pkg.sv
// Default sizing and state encoding for the variable-window moving average.
package settings_pkg;
  import functions_pkg::*;

  localparam int MAX_WINDOW  = 64;
  localparam int DATA_SIZE   = 16;
  localparam int WINDOW_SIZE = clog2(MAX_WINDOW);
  localparam int FULL_SIZE   = DATA_SIZE + WINDOW_SIZE;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } ma_state_t;

endpackage

// File: rtl/ma_delay_line.sv
// Circular sample history: writes each accepted sample and returns, one cycle
// later, the sample accepted 2**window_log2 samples earlier.
module ma_delay_line
  import functions_pkg::*;
#(
  parameter int MAX_WINDOW = 64,
  parameter int DATA_SIZE  = 16
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    wr_en,
  input  logic signed [DATA_SIZE-1:0]             wr_data,
  input  logic [clog2(clog2(MAX_WINDOW)+1)-1:0]   window_log2,
  output logic signed [DATA_SIZE-1:0]             rd_data
);

  localparam int AW = clog2(MAX_WINDOW);

  logic signed [DATA_SIZE-1:0] mem [MAX_WINDOW];
  logic [AW-1:0]               wr_ptr;
  logic [AW-1:0]               rd_addr;
  logic [AW:0]                 span;

  // A full-depth window (span == MAX_WINDOW) reads the slot about to be
  // overwritten, which still holds the oldest sample.
  always_comb begin
    span    = (AW+1)'(1) << window_log2;
    rd_addr = wr_ptr - span[AW-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
    end else if (wr_en) begin
      wr_ptr <= wr_ptr + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
      rd_data     <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/moving_average_var.sv
// Moving average over a runtime-selectable power-of-two window, two-cycle
// latency, one sample per cycle, full-precision running sum.
module moving_average_var
  import functions_pkg::*;
#(
  parameter int MAX_WINDOW = settings_pkg::MAX_WINDOW,
  parameter int DATA_SIZE  = settings_pkg::DATA_SIZE
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          clear,
  input  logic [clog2(clog2(MAX_WINDOW)+1)-1:0]         window_log2,
  input  logic                                          in_valid,
  input  logic signed [DATA_SIZE-1:0]                   in_data,
  output logic                                          out_valid,
  output logic signed [DATA_SIZE-1:0]                   out_avg,
  output logic signed [DATA_SIZE+clog2(MAX_WINDOW)-1:0] out_sum,
  output logic                                          out_filled
);
  import settings_pkg::ma_state_t;
  import settings_pkg::FILL;
  import settings_pkg::RUN;

  localparam int WINDOW_SIZE = clog2(MAX_WINDOW);
  localparam int FULL_SIZE   = DATA_SIZE + WINDOW_SIZE;
  localparam int WL_W        = clog2(WINDOW_SIZE + 1);
  localparam int CNT_W       = WINDOW_SIZE + 1;
  localparam logic [WL_W-1:0] WL_MAX = WL_W'(WINDOW_SIZE);

  function automatic logic signed [FULL_SIZE-1:0] sext(input logic signed [DATA_SIZE-1:0] x);
    return {{WINDOW_SIZE{x[DATA_SIZE-1]}}, x};
  endfunction

  // Arithmetic shift floors toward minus infinity; in RUN the quotient always fits.
  function automatic logic signed [DATA_SIZE-1:0] floor_avg(input logic signed [FULL_SIZE-1:0] s,
                                                            input logic [WL_W-1:0] sh);
    logic signed [FULL_SIZE-1:0] q;
    q = s >>> sh;
    return q[DATA_SIZE-1:0];
  endfunction

  ma_state_t                   state, state_nxt;
  logic                        accept, restart, sub;
  logic [WL_W-1:0]             wl_req, active_wl;
  logic                        active_vld;
  logic [CNT_W-1:0]            cnt, cnt_base, cnt_nxt, span;

  logic                        vld_p0, sub_p0, restart_p0, filled_p0;
  logic signed [DATA_SIZE-1:0] x_p0, old_p0;
  logic [WL_W-1:0]             wl_p0;

  logic signed [FULL_SIZE-1:0] acc_p1, acc_nxt;

  // ---- stage 0: window selection, fill tracking, history access ----
  always_comb begin
    accept   = in_valid && !clear;
    wl_req   = (window_log2 > WL_MAX) ? WL_MAX : window_log2;
    span     = CNT_W'(1) << wl_req;
    restart  = !active_vld || (wl_req != active_wl);
    cnt_base = restart ? '0 : cnt;
    sub      = !restart && (state == RUN);
    cnt_nxt  = (cnt_base == span) ? cnt_base : cnt_base + CNT_W'(1);
    state_nxt = state;
    if (accept) begin
      state_nxt = (cnt_nxt == span) ? RUN : FILL;
    end
    if (clear) begin
      state_nxt = FILL;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      active_vld <= 1'b0;
      active_wl  <= '0;
      vld_p0     <= 1'b0;
    end else if (clear) begin
      cnt    <= '0;
      vld_p0 <= 1'b0;
    end else begin
      vld_p0 <= accept;
      if (accept) begin
        cnt        <= cnt_nxt;
        active_vld <= 1'b1;
        active_wl  <= wl_req;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      x_p0       <= in_data;
      sub_p0     <= sub;
      restart_p0 <= restart;
      filled_p0  <= (cnt_nxt == span);
      wl_p0      <= wl_req;
    end
  end

  ma_delay_line #(
    .MAX_WINDOW (MAX_WINDOW),
    .DATA_SIZE  (DATA_SIZE)
  ) u_delay (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (accept),
    .wr_data     (in_data),
    .window_log2 (wl_req),
    .rd_data     (old_p0)
  );

  // ---- stage 1: accumulate and register outputs ----
  always_comb begin
    acc_nxt = (restart_p0 ? '0 : acc_p1) + sext(x_p0) - (sub_p0 ? sext(old_p0) : '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_p1     <= '0;
      out_valid  <= 1'b0;
      out_sum    <= '0;
      out_avg    <= '0;
      out_filled <= 1'b0;
    end else if (clear) begin
      acc_p1    <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= vld_p0;
      if (vld_p0) begin
        acc_p1     <= acc_nxt;
        out_sum    <= acc_nxt;
        out_avg    <= floor_avg(acc_nxt, wl_p0);
        out_filled <= filled_p0;
      end
    end
  end

endmodule

// File: tb/tb_moving_average_var.sv
// Directed bench for moving_average_var: hand-computed vectors plus a
// window-history reference model for the gap and reset-resume streams.
module tb_moving_average_var;

  logic               clk = 1'b0;
  logic               reset, clear, in_valid;
  logic [2:0]         window_log2;
  logic signed [15:0] in_data;
  logic               out_valid;
  logic signed [15:0] out_avg;
  logic signed [21:0] out_sum;
  logic               out_filled;

  moving_average_var #(.MAX_WINDOW(64), .DATA_SIZE(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .window_log2 (window_log2),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_avg     (out_avg),
    .out_sum     (out_sum),
    .out_filled  (out_filled)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint due;
    longint s;
    longint a;
    bit     f;
    string  tag;
  } exp_t;

  localparam int S30[6] = '{100, 200, 300, 400, 400, 400};
  localparam int A30[6] = '{25, 50, 75, 100, 100, 100};
  localparam int F30[6] = '{0, 0, 0, 1, 1, 1};
  localparam int X31[3] = '{-1, -1, -3};
  localparam int S31[3] = '{-1, -2, -4};
  localparam int A31[3] = '{-1, -1, -2};
  localparam int F31[3] = '{0, 1, 1};

  int     vectors = 0;
  int     miscompares = 0;
  longint ncyc = 0;
  exp_t   eq[$];

  logic signed [15:0] mh[$];
  int     m_wl = 0;
  bit     m_act = 0;
  longint m_s, m_a;
  bit     m_f;

  always @(posedge clk) ncyc <= ncyc + 1;

  task automatic check(input string tag, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Reference: keep only the samples of the current window, sum them directly.
  task automatic model_step(input int x, input int wl_raw);
    int wl;
    wl = (wl_raw > 6) ? 6 : wl_raw;
    if (!m_act || wl != m_wl) begin
      mh.delete();
      m_wl  = wl;
      m_act = 1;
    end
    mh.push_back(16'(x));
    if (mh.size() > (1 << wl)) void'(mh.pop_front());
    m_s = 0;
    foreach (mh[i]) m_s += longint'(mh[i]);
    m_a = m_s >>> wl;
    m_f = (mh.size() == (1 << wl));
  endtask

  task automatic drive(input int x, input int wl);
    @(negedge clk);
    clear       = 1'b0;
    in_valid    = 1'b1;
    in_data     = 16'(x);
    window_log2 = 3'(wl);
  endtask

  task automatic enqueue(input string tag, input longint es, input longint ea, input bit ef);
    exp_t e;
    e.due = ncyc + 2;
    e.s   = es;
    e.a   = ea;
    e.f   = ef;
    e.tag = tag;
    eq.push_back(e);
  endtask

  task automatic push_exp(input string tag, input int x, input int wl,
                          input longint es, input longint ea, input bit ef);
    drive(x, wl);
    model_step(x, wl);
    enqueue(tag, es, ea, ef);
  endtask

  task automatic push_model(input string tag, input int x, input int wl);
    drive(x, wl);
    model_step(x, wl);
    enqueue(tag, m_s, m_a, m_f);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      clear    = 1'b0;
    end
  endtask

  task automatic drop_after(input longint c);
    while (eq.size() > 0 && eq[eq.size()-1].due > c) void'(eq.pop_back());
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"},  longint'(out_valid),  0);
    check({tag, "_sum"},    longint'(out_sum),    0);
    check({tag, "_avg"},    longint'(out_avg),    0);
    check({tag, "_filled"}, longint'(out_filled), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (out_valid === 1'b1) begin
      if (eq.size() == 0) begin
        check("spurious_valid", longint'(out_valid), 0);
      end else begin
        e = eq.pop_front();
        check({e.tag, "_latency"}, ncyc, e.due);
        check({e.tag, "_sum"},     longint'(out_sum), e.s);
        check({e.tag, "_avg"},     longint'(out_avg), e.a);
        check({e.tag, "_filled"},  longint'(out_filled), longint'(e.f));
      end
    end else if (eq.size() > 0 && eq[0].due < ncyc) begin
      e = eq.pop_front();
      check({e.tag, "_valid"}, longint'(out_valid), 1);
    end
  end

  initial begin
    longint s, c;
    int wait_cnt;
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; window_log2 = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;

    for (int i = 0; i < 6; i++) push_exp("n4_const", 100, 2, S30[i], A30[i], F30[i] != 0);
    for (int i = 0; i < 3; i++) push_exp("n2_floor", X31[i], 1, S31[i], A31[i], F31[i] != 0);

    for (int i = 0; i < 4; i++) push_exp("n4_eights", 8, 2, 8 * (i + 1), 2 * (i + 1), i == 3);
    push_exp("shrink_first", 2, 1, 2, 1, 0);
    push_exp("shrink_second", 2, 1, 4, 2, 1);

    for (int k = 1; k <= 70; k++) begin
      s = longint'(k > 64 ? 64 : k) * 32767;
      push_exp("n64_pos", 32767, 6, s, s >>> 6, k >= 64);
    end
    for (int j = 1; j <= 64; j++) begin
      s = longint'(64 - j) * 32767 - longint'(j) * 32768;
      push_exp("n64_neg", -32768, 6, s, s >>> 6, 1);
    end
    push_exp("clamp", 0, 7, -2064384, -32256, 1);
    idle(3);

    push_exp("pre_clear0", 5, 2, 5, 1, 0);
    push_exp("pre_clear1", 6, 2, 11, 2, 0);
    @(negedge clk);
    clear = 1'b1; in_valid = 1'b1; in_data = 16'sd77;
    c = ncyc;
    drop_after(c);
    mh.delete();
    push_exp("post_clear", 9, 2, 9, 2, 0);
    idle(3);

    for (int i = 0; i < 48; i++) begin
      if ($urandom_range(0, 3) != 0)
        push_model("gaps", int'($urandom_range(0, 65535)) - 32768, (i < 24) ? 3 : 1);
      else
        idle(1);
    end

    for (int i = 0; i < 5; i++) push_model("pre_reset", 1000 + 37 * i, 3);
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0;
    c = ncyc;
    drop_after(c);
    mh.delete();
    m_act = 0;
    @(negedge clk);
    check_zero("midreset");
    reset = 1'b0;
    for (int i = 0; i < 12; i++) push_model("resume", i * 111 - 500, 3);
    idle(1);

    wait_cnt = 0;
    while (eq.size() > 0 && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    check("drain_pending", longint'(eq.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/moving_average_var.md
MOVING_AVERAGE_VAR -- requirements
Module: moving_average_var

Interface
REQ-001 SHALL have parameter MAX_WINDOW, default 64, maximum window length in samples; power of two, 2..1024.
REQ-002 SHALL have parameter DATA_SIZE, default 16, signed sample width in bits.
REQ-003 SHALL derive WINDOW_SIZE = clog2(MAX_WINDOW) and FULL_SIZE = DATA_SIZE + WINDOW_SIZE; neither is user-overridable.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port clear  input  1  synchronous flush of history, sum and fill count; configuration kept.
REQ-007 SHALL have port window_log2  input  clog2(WINDOW_SIZE+1)  requested window N = 2**window_log2.
REQ-008 SHALL have port in_valid  input  1  qualifies in_data.
REQ-009 SHALL have port in_data  input  DATA_SIZE  signed input sample.
REQ-010 SHALL have port out_valid  output  1  qualifies out_avg and out_sum.
REQ-011 SHALL have port out_avg  output  DATA_SIZE  signed average.
REQ-012 SHALL have port out_sum  output  FULL_SIZE  signed running sum.
REQ-013 SHALL have port out_filled  output  1  high once N samples are accumulated in the current window.

Function
REQ-014 SHALL accept one sample per cycle with in_valid high; no back-pressure; in_valid low cycles are gaps that do not advance state.
REQ-015 SHALL assert out_valid exactly 2 cycles after each accepted sample, one pulse per sample, order preserved.
REQ-016 SHALL keep a circular history of MAX_WINDOW samples; write pointer wraps MAX_WINDOW-1 -> 0.
REQ-017 SHALL compute sum_new = sum + x - x_old, where x_old is the sample accepted N samples earlier, or 0 while fill count < N.
REQ-018 SHALL use state machine FILL (count < N, no subtraction) -> RUN (count == N, subtract); FILL -> RUN on the sample making count == N.
REQ-019 SHALL saturate the fill counter at N; out_filled = 1 in RUN, 0 in FILL, and it is registered with its output sample.
REQ-020 SHALL produce out_avg = out_sum arithmetically shifted right by window_log2 (floor toward minus infinity), truncated to DATA_SIZE; out_avg is lossless in RUN.
REQ-021 SHALL sign-extend all arithmetic to FULL_SIZE; the sum never overflows for any input sequence.
REQ-022 SHALL clamp window_log2 > WINDOW_SIZE to WINDOW_SIZE.
REQ-023 SHALL sample window_log2 only on accepted samples; a value differing from the active one SHALL reset sum and count to zero and enter FILL, and that sample becomes the first of the new window.
REQ-024 SHALL give clear priority over a simultaneous in_valid: the sample is discarded, no out_valid is produced for it, and samples already in the pipeline are dropped.
REQ-025 SHALL make the history RAM content irrelevant after reset or clear; no RAM initialisation cycles and no stall.

Reset
REQ-026 SHALL, on reset, clear out_valid, out_avg, out_sum, out_filled, sum, fill count, pipeline valids and write pointer to 0, set state FILL, and set active window to window_log2 sampled on the first accepted sample.
REQ-027 SHALL, on reset asserted mid-stream, abort in-flight samples; the first out_valid occurs 2 cycles after the first sample accepted after reset deasserts.

Structure
REQ-028 SHALL keep MAX_WINDOW, DATA_SIZE, WINDOW_SIZE, FULL_SIZE and the FILL/RUN state enum typedef in settings_pkg; clog2 comes from functions_pkg.
REQ-029 SHALL place the circular history (write pointer, registered read at pointer - N) in sub-module ma_delay_line; the accumulator, FSM and output registers remain in moving_average_var.

Verification
REQ-030 SHALL cover: N=4 (log2=2), constant 100 every cycle -> out_sum 100,200,300,400,400...; out_avg 25,50,75,100,100...; out_filled rises on the 4th output.
REQ-031 SHALL cover: N=2, inputs -1,-1,-3 -> out_sum -1,-2,-4; out_avg -1,-1,-2 (floor).
REQ-032 SHALL cover: N=64, 70 samples of 32767, then 64 of -32768 -> peak out_sum 2097088, final out_sum -2097152, out_avg -32768, no wrap.
REQ-033 SHALL cover: N=4 filled with 8s, then window_log2=1 with sample 2 -> out_sum 2, out_filled 0; next sample 2 -> out_sum 4, out_avg 2, out_filled 1.
REQ-034 SHALL cover: random in_valid gaps vs. golden model -> identical outputs; clear with in_valid high -> sample dropped, next sample yields out_sum = that sample.
REQ-035 SHALL cover: reset pulse mid-stream at N=8 -> outputs zero next cycle; resumed stream matches a fresh-start model.
